// File: rtl/synth_pkg.sv
// Shared widths and the quarter-wave phase fold used by the sine ROM arbiter.
// Latency: none (constants and a pure combinational function).
// Backpressure: n/a.
package synth_pkg;

  localparam int PHASE_W    = 7;
  localparam int ROM_ADDR_W = 5;
  localparam int ROM_AMPL_W = 6;
  localparam int SAMPLE_W   = 7;

  // Returns {sign, addr}. The quadrant bit p[5] mirrors the index, so that
  // 31-idx walks the table backwards; the top bit p[6] gives the sign.
  function automatic logic [ROM_ADDR_W:0] phase_fold(input logic [PHASE_W-1:0] p);
    logic [ROM_ADDR_W-1:0] idx;
    idx = p[ROM_ADDR_W-1:0];
    return {p[PHASE_W-1], (p[ROM_ADDR_W] ? ~idx : idx)};
  endfunction

endpackage

// File: rtl/sin_rom_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus binary id, pointer advances past the winner.
// Latency: grant is combinational in the request cycle; pointer updates on the next edge.
// Backpressure: enable low (or reset held) suppresses all grants; pointer then holds.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_vld,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W:0]   cand;
  logic [ID_W:0]   nxt;

  // Search from ptr upward with wrap; the first active request wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    if (rstn && enable) begin
      for (int k = 0; k < N; k++) begin
        cand = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(N)) cand = cand - (ID_W+1)'(N);
        if (!gnt_vld && req[cand[ID_W-1:0]]) begin
          gnt_vld                  = 1'b1;
          gnt_id                   = cand[ID_W-1:0];
          gnt[cand[ID_W-1:0]]      = 1'b1;
        end
      end
    end
  end

  // Next pointer: one past the winner, unchanged when nothing was granted.
  always_comb begin
    nxt   = {1'b0, gnt_id} + (ID_W+1)'(1);
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (nxt == (ID_W+1)'(N)) ? '0 : nxt[ID_W-1:0];
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sin_rom_arbiter.sv
// Shares one quarter-wave sine ROM among N_REQ voices; folds phase, returns signed tagged samples.
// Latency: 3 cycles from grant to rsp_valid; one sample per cycle throughput.
// Backpressure: none downstream; enable low stops new grants while in-flight samples drain.
module sin_rom_arbiter
  import synth_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req,
  input  logic [PHASE_W*N_REQ-1:0] phase,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rom_en,
  output logic [ROM_ADDR_W-1:0]    rom_addr,
  input  logic [ROM_AMPL_W-1:0]    rom_data,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [SAMPLE_W-1:0]      rsp_sample
);

  logic                  gnt_vld;
  logic [ID_W-1:0]       gnt_id;
  logic [PHASE_W-1:0]    phase_arr [N_REQ];
  logic [ROM_ADDR_W:0]   fold;

  // Stage 1 travels with the ROM access, stage 2 with the ROM data.
  logic                  rom_en_q;
  logic [ROM_ADDR_W-1:0] rom_addr_q;
  logic                  s1_sign_q;
  logic [ID_W-1:0]       s1_id_q;
  logic                  s2_vld_q;
  logic                  s2_sign_q;
  logic [ID_W-1:0]       s2_id_q;

  logic                  rsp_valid_q;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [SAMPLE_W-1:0]   rsp_sample_q, rsp_sample_d;
  logic [SAMPLE_W-1:0]   ampl;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .enable  (enable),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // Unpack phases and fold the winner's phase onto the quarter-wave table.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) phase_arr[i] = phase[i*PHASE_W +: PHASE_W];
    fold = phase_fold(phase_arr[gnt_id]);
  end

  // ROM request stage and the sign/id shadow pipeline; idle slots carry zeros.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      s1_sign_q  <= 1'b0;
      s1_id_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      rom_en_q   <= gnt_vld;
      rom_addr_q <= gnt_vld ? fold[ROM_ADDR_W-1:0] : '0;
      s1_sign_q  <= gnt_vld & fold[ROM_ADDR_W];
      s1_id_q    <= gnt_vld ? gnt_id : '0;
      s2_vld_q   <= rom_en_q;
      s2_sign_q  <= s1_sign_q;
      s2_id_q    <= s1_id_q;
    end
  end

  // Apply sign to the ROM amplitude; outputs are forced to zero on empty slots.
  always_comb begin
    ampl         = {1'b0, rom_data};
    rsp_sample_d = '0;
    rsp_id_d     = '0;
    if (s2_vld_q) begin
      rsp_sample_d = s2_sign_q ? SAMPLE_W'(-ampl) : ampl;
      rsp_id_d     = s2_id_q;
    end
  end

  // Output sample register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sample_q <= '0;
    end else begin
      rsp_valid_q  <= s2_vld_q;
      rsp_id_q     <= rsp_id_d;
      rsp_sample_q <= rsp_sample_d;
    end
  end

  assign rom_en     = rom_en_q;
  assign rom_addr   = rom_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_sample = rsp_sample_q;

endmodule

// File: tb/tb_sin_rom_arbiter.sv
// Bench for sin_rom_arbiter: sine ROM model, directed cases and randomized traffic.
// Reference model tracks the round-robin pointer and a queue of expected responses.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_sin_rom_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic [N-1:0]  req = '0;
  logic [7*N-1:0] phase = '0;
  logic [N-1:0]  gnt;
  logic          rom_en;
  logic [4:0]    rom_addr;
  logic [5:0]    rom_data = '0;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [6:0]    rsp_sample;

  sin_rom_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .req        (req),
    .phase      (phase),
    .gnt        (gnt),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sample (rsp_sample)
  );

  always #5 clk = ~clk;

  // Quarter-wave table: round(31*sin(pi/2 * a/31)).
  int tbl [32];
  initial for (int a = 0; a < 32; a++) tbl[a] = $rtoi(31.0 * $sin(3.14159265358979 * a / 62.0) + 0.5);

  // Registered ROM.
  always @(posedge clk) if (rom_en) rom_data <= 6'(tbl[rom_addr]);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct { int due; int id; logic [6:0] smp; } rsp_t;
  rsp_t q[$];
  int   m_ptr = 0;
  int   cyc = 0;
  bit   prev_vld = 0;
  int   prev_addr = 0;

  logic [N-1:0] obs_gnt;
  logic [4:0]   obs_rom_addr;
  logic         obs_rsp_valid;
  logic [1:0]   obs_rsp_id;
  logic [6:0]   obs_rsp_sample;

  // One clock cycle: drive, check against the model at negedge, advance.
  task automatic cycle_run(input logic en, input logic [N-1:0] rq, input logic [7*N-1:0] ph);
    logic [N-1:0] eg;
    int gi, p, sgn, mir, idx, addr, amp, s;
    bit ev;
    rsp_t r;
    enable = en; req = rq; phase = ph;
    @(negedge clk);
    eg = '0; gi = -1; addr = 0;
    if (en) for (int k = 0; k < N; k++) if (gi < 0 && rq[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
    if (gi >= 0) eg[gi] = 1'b1;
    check("gnt", 32'(gnt), 32'(eg));
    obs_gnt = gnt;
    check("rom_en", 32'(rom_en), 32'(prev_vld));
    if (prev_vld) check("rom_addr", 32'(rom_addr), 32'(prev_addr));
    obs_rom_addr = rom_addr;
    ev = (q.size() > 0 && q[0].due == cyc);
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      r = q.pop_front();
      check("rsp_id", 32'(rsp_id), 32'(r.id));
      check("rsp_sample", 32'(rsp_sample), 32'(r.smp));
    end else begin
      check("rsp_id_idle", 32'(rsp_id), 0);
      check("rsp_sample_idle", 32'(rsp_sample), 0);
    end
    obs_rsp_valid = rsp_valid; obs_rsp_id = rsp_id; obs_rsp_sample = rsp_sample;
    if (gi >= 0) begin
      p    = int'(ph[7*gi +: 7]);
      sgn  = p / 64;
      mir  = (p / 32) % 2;
      idx  = p % 32;
      addr = mir ? 31 - idx : idx;
      amp  = tbl[addr];
      s    = sgn ? -amp : amp;
      r.due = cyc + 3; r.id = gi; r.smp = 7'(s);
      q.push_back(r);
      m_ptr = (gi + 1) % N;
    end
    prev_vld = (gi >= 0);
    prev_addr = addr;
    @(posedge clk); cyc++; #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must clear at once.
  task automatic reset_pulse();
    rstn = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rom_en", 32'(rom_en), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_sample", 32'(rsp_sample), 0);
    q.delete(); m_ptr = 0; prev_vld = 0; prev_addr = 0;
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1 rstn = 1'b1;
  endtask

  // Lone request on voice v; checks fold address at T+1 and sample at T+3.
  task automatic single(input int v, input logic [6:0] ph, input int exp_addr, input logic [6:0] exp_smp);
    logic [7*N-1:0] pv;
    pv = '0;
    pv[7*v +: 7] = ph;
    cycle_run(1'b1, N'(1) << v, pv);
    cycle_run(1'b1, '0, '0);
    check("dir_addr", 32'(obs_rom_addr), 32'(exp_addr));
    cycle_run(1'b1, '0, '0);
    cycle_run(1'b1, '0, '0);
    check("dir_valid", 32'(obs_rsp_valid), 1);
    check("dir_id", 32'(obs_rsp_id), 32'(v));
    check("dir_sample", 32'(obs_rsp_sample), 32'(exp_smp));
  endtask

  initial begin
    int nv;
    logic [7*N-1:0] rph;
    #2;
    reset_pulse();

    // Directed fold cases.
    single(0, 7'd0,   0,  7'd0);
    single(1, 7'd31,  31, 7'd31);
    single(1, 7'd32,  31, 7'd31);
    single(1, 7'd63,  0,  7'd0);
    single(2, 7'd72,  8,  7'h74);
    single(2, 7'd127, 0,  7'd0);

    // Round-robin with all voices requesting continuously from reset.
    reset_pulse();
    for (int c = 0; c < 12; c++) begin
      cycle_run(1'b1, 4'hF, 28'($urandom));
      check("rr_order", 32'(obs_gnt), 32'(1 << (c % 4)));
      if (c >= 3) check("rr_rsp_id", 32'(obs_rsp_id), 32'((c - 3) % 4));
    end

    // Enable dropped right after voice 0's grant.
    reset_pulse();
    cycle_run(1'b1, 4'hF, 28'($urandom));
    check("en_first", 32'(obs_gnt), 1);
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      cycle_run(1'b0, 4'hE, 28'($urandom));
      if (obs_rsp_valid) nv++;
    end
    check("en_drain_count", 32'(nv), 1);
    cycle_run(1'b1, 4'hE, 28'($urandom));
    check("en_resume", 32'(obs_gnt), 32'(4'b0010));

    // Reset with three requests in flight.
    cycle_run(1'b1, 4'hF, 28'($urandom));
    cycle_run(1'b1, 4'hF, 28'($urandom));
    reset_pulse();
    for (int c = 0; c < 4; c++) cycle_run(1'b0, 4'hE, 28'($urandom));
    cycle_run(1'b1, 4'hE, 28'($urandom));
    check("rst_first_gnt", 32'(obs_gnt), 32'(4'b0010));

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rph = 28'($urandom);
      cycle_run(($urandom_range(0, 9) != 0), 4'($urandom), rph);
    end
    for (int c = 0; c < 4; c++) cycle_run(1'b1, '0, '0);
    check("queue_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
